// File: rtl/lut_arbiter_if.sv
// lut_arbiter_if: requester and LUT bus shared by lut_arbiter and its users.
// Carries req/addr/gnt, the tagged response, and the shared lut read port.
interface lut_arbiter_if #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int AW = 8
);
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [W-1:0]    rsp_data;
    logic            rsp_err;
    logic [AW-1:0]   lut_addr;
    logic [W-1:0]    lut_data;

    // Environment side: requesters plus the attached lut.
    modport master (
        output req, addr, lut_data,
        input  gnt, rsp_valid, rsp_data, rsp_err, lut_addr
    );

    // Arbiter side.
    modport slave (
        input  req, addr, lut_data,
        output gnt, rsp_valid, rsp_data, rsp_err, lut_addr
    );
endinterface

// File: rtl/lut_arbiter.sv
// lut_arbiter: shares one registered lut read port among N requesters.
// Ports: clk, reset_n (sync, active-low), bus (lut_arbiter_if.slave):
//   req/addr in, gnt out (combinational), rsp_valid/rsp_data/rsp_err out
//   one cycle after grant, lut_addr out, lut_data in.
// Macro LUT_ARB_FIXED_PRIO_EN: lowest index wins instead of round-robin.
module lut_arbiter #(
    parameter int N  = 4,
    parameter int L  = 256,
    parameter int W  = 8,
    parameter int AW = $clog2(L)
) (
    input  logic           clk,
    input  logic           reset_n,
    lut_arbiter_if.slave   bus
);

    localparam int          PW  = $clog2(N);
    localparam logic [AW:0] LIM = (AW+1)'(L);

    logic          win_vld;
    logic [PW-1:0] win_idx;
    logic [AW-1:0] win_addr;
    logic          win_oor;
    logic          grant;

    logic          rsp_vld_q, rsp_vld_d;
    logic [PW-1:0] rsp_idx_q, rsp_idx_d;
    logic          rsp_oor_q, rsp_oor_d;

`ifdef LUT_ARB_FIXED_PRIO_EN

    // Scan downwards so the lowest requesting index is the last to land.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win_vld = 1'b1;
                win_idx = PW'(i);
            end
        end
    end

`else

    logic [PW-1:0] ptr_q, ptr_d;

    // First requester at or after ptr, wrapping past N-1 to 0.
    always_comb begin
        int j;
        j       = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (!win_vld && bus.req[j]) begin
                win_vld = 1'b1;
                win_idx = PW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            if (int'(win_idx) == N - 1) ptr_d = '0;
            else                        ptr_d = win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

`endif

    // Grant and lut address are forced idle while reset is asserted.
    always_comb begin
        win_addr     = bus.addr[int'(win_idx)*AW +: AW];
        win_oor      = {1'b0, win_addr} >= LIM;
        grant        = reset_n & win_vld;
        bus.gnt      = grant ? (N'(1) << win_idx) : '0;
        // Out-of-range addresses never reach the table.
        bus.lut_addr = (grant && !win_oor) ? win_addr : '0;
        rsp_vld_d    = grant;
        rsp_idx_d    = win_idx;
        rsp_oor_d    = win_oor;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_vld_q <= 1'b0;
            rsp_idx_q <= '0;
            rsp_oor_q <= 1'b0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_idx_q <= rsp_idx_d;
            rsp_oor_q <= rsp_oor_d;
        end
    end

    // lut_data is already registered by the lut, aligned with rsp_*_q.
    always_comb begin
        bus.rsp_valid = '0;
        if (rsp_vld_q) bus.rsp_valid[rsp_idx_q] = 1'b1;
        bus.rsp_data = (rsp_vld_q && !rsp_oor_q) ? bus.lut_data : '0;
        bus.rsp_err  = rsp_vld_q & rsp_oor_q;
    end

endmodule

// File: tb/tb_lut_arbiter.sv
// tb_lut_arbiter: directed and random checks of lut_arbiter with a ROM
// model attached, against a behavioural arbitration/response model.
module tb_lut_arbiter;

    localparam int N  = 4;
    localparam int L  = 200;
    localparam int W  = 8;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    lut_arbiter_if #(.N(N), .W(W), .AW(AW)) bus ();

    lut_arbiter #(.N(N), .L(L), .W(W), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [W-1:0] rom [256];

    function automatic logic [7:0] romf(input int a);
        return 8'((a * 7 + 3) & 255);
    endfunction

    // Attached registered lut, held in reset with the arbiter.
    always @(posedge clk) begin
        if (!reset_n) bus.lut_data <= '0;
        else          bus.lut_data <= rom[bus.lut_addr];
    end

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Behavioural model: rotation pointer and one pending response.
    int          m_ptr  = 0;
    bit          p_vld  = 1'b0;
    int          p_idx  = 0;
    bit          p_oor  = 1'b0;
    logic [7:0]  p_data = '0;

    always @(negedge clk) begin : cmp
        int         w;
        int         idx;
        logic [7:0] a;
        bit         oor;
        logic [3:0] eg;
        logic [7:0] ea;
        if (chk_en) begin
            w = -1;
            if (reset_n) begin
                for (int k = 0; k < N; k++) begin
`ifdef LUT_ARB_FIXED_PRIO_EN
                    idx = k;
`else
                    idx = (m_ptr + k) % N;
`endif
                    if (w < 0 && bus.req[idx]) w = idx;
                end
            end
            a   = (w >= 0) ? bus.addr[w*AW +: AW] : 8'd0;
            oor = (w >= 0) && (int'(a) >= L);
            eg  = (w >= 0) ? (4'b1 << w) : 4'b0;
            ea  = (w >= 0 && !oor) ? a : 8'd0;
            chk("m_gnt", bus.gnt, eg);
            chk("m_lut_addr", bus.lut_addr, ea);
            chk("m_rsp_valid", bus.rsp_valid,
                p_vld ? (4'b1 << p_idx) : 4'b0);
            chk("m_rsp_err", bus.rsp_err, p_vld & p_oor);
            chk("m_rsp_data", bus.rsp_data,
                (p_vld && !p_oor) ? p_data : 8'd0);
            if (!reset_n) begin
                m_ptr = 0;
                p_vld = 1'b0;
            end else begin
                p_vld = (w >= 0);
                if (w >= 0) begin
                    p_idx  = w;
                    p_oor  = oor;
                    p_data = oor ? 8'd0 : rom[a];
                    m_ptr  = (w + 1) % N;
                end
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic [31:0] ad,
                         input logic rn);
        @(posedge clk);
        #1;
        bus.req  = r;
        bus.addr = ad;
        reset_n  = rn;
    endtask

    logic [3:0]  exp_g;
    logic [3:0]  seq_r [4];
    logic [3:0]  seq_g [4];
    logic [31:0] ra;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = romf(i);
        bus.req  = '0;
        bus.addr = '0;
        reset_n  = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;

        // Reset with everyone requesting.
        drive(4'b1111, 32'h0, 1'b0);
        @(negedge clk);
        chk("rst_gnt", bus.gnt, 4'b0);
        chk("rst_lut_addr", bus.lut_addr, 8'd0);
        drive(4'b1111, 32'h0, 1'b0);
        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 4'b0);
        chk("rst_rsp_data", bus.rsp_data, 8'd0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);

        // Single requester, address 5.
        drive(4'b0001, 32'h0000_0005, 1'b1);
        @(negedge clk);
        chk("single_gnt", bus.gnt, 4'b0001);
        chk("single_lut_addr", bus.lut_addr, 8'd5);
        chk("single_no_rsp", bus.rsp_valid, 4'b0);
        drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        chk("single_rsp_valid", bus.rsp_valid, 4'b0001);
        chk("single_rsp_data", bus.rsp_data, 8'd38);
        chk("single_rsp_err", bus.rsp_err, 1'b0);

        // All requesting after reset.
        drive(4'b0000, 32'h0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, 32'h281E_140A, 1'b1);
            @(negedge clk);
`ifdef LUT_ARB_FIXED_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = 4'b1 << (k % 4);
`endif
            chk("all_gnt", bus.gnt, exp_g);
            if (k > 0) begin
`ifdef LUT_ARB_FIXED_PRIO_EN
                chk("all_rsp", bus.rsp_valid, 4'b0001);
`else
                chk("all_rsp", bus.rsp_valid, 4'b1 << ((k - 1) % 4));
`endif
            end
        end

        // Out-of-range address on requester 2.
        drive(4'b0100, 32'h00FA_0000, 1'b1);
        @(negedge clk);
        chk("oor_gnt", bus.gnt, 4'b0100);
        chk("oor_lut_addr", bus.lut_addr, 8'd0);
        drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        chk("oor_rsp_valid", bus.rsp_valid, 4'b0100);
        chk("oor_rsp_err", bus.rsp_err, 1'b1);
        chk("oor_rsp_data", bus.rsp_data, 8'd0);

        // Pointer wrap from 3.
        for (int k = 0; k < 3; k++) begin
            drive(4'b1001, 32'h0300_0001, 1'b1);
            @(negedge clk);
`ifdef LUT_ARB_FIXED_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = (k == 1) ? 4'b0001 : 4'b1000;
`endif
            chk("wrap_gnt", bus.gnt, exp_g);
        end

        // Reset mid-operation.
        drive(4'b0010, 32'h0000_0700, 1'b0);
        @(negedge clk);
        chk("midrst_gnt", bus.gnt, 4'b0);
        drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        chk("midrst_rsp_valid", bus.rsp_valid, 4'b0);
        drive(4'b0011, 32'h0000_0908, 1'b1);
        @(negedge clk);
        chk("midrst_first_gnt", bus.gnt, 4'b0001);

        // Withdrawn request on 1.
        drive(4'b0000, 32'h0, 1'b0);
        seq_r[0] = 4'b1011; seq_r[1] = 4'b1001;
        seq_r[2] = 4'b1011; seq_r[3] = 4'b1001;
`ifdef LUT_ARB_FIXED_PRIO_EN
        seq_g[0] = 4'b0001; seq_g[1] = 4'b0001;
        seq_g[2] = 4'b0001; seq_g[3] = 4'b0001;
`else
        seq_g[0] = 4'b0001; seq_g[1] = 4'b1000;
        seq_g[2] = 4'b0001; seq_g[3] = 4'b1000;
`endif
        for (int k = 0; k < 4; k++) begin
            drive(seq_r[k], 32'h0400_0201, 1'b1);
            @(negedge clk);
            chk("wd_gnt", bus.gnt, seq_g[k]);
        end
        drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);
        chk("wd_no_rsp1", bus.rsp_valid[1], 1'b0);

        // Random traffic, occasional resets, some out-of-range addresses.
        for (int k = 0; k < 3000; k++) begin
            ra = $urandom;
            drive(4'($urandom), ra, ($urandom_range(0, 99) != 0));
        end
        drive(4'b0000, 32'h0, 1'b1);
        drive(4'b0000, 32'h0, 1'b1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
